// File: rtl/param_fifo_buffer.sv
// rtl/param_fifo_buffer.sv - parametrised FWFT circular FIFO with occupancy flags and sticky errors
//
// Purpose: DEPTH = 2**ADDR_WIDTH entry first-word-fall-through FIFO placed between
// clause-evaluation producers and FIFO-tree arbiters. almost_full_o lets the producer
// back off before words would be refused.
//
// Optional feature macro: FIFO_WATERMARK_EN (adds wm_clear_i / high_water_o).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   clear_i               synchronous flush (same effect on FIFO state as reset)
//   wr_data_i/valid/ready push interface (wr_ready_o = !full_o)
//   rd_data_o/valid/ready pop interface, rd_data_o is the current head
//   count_o               occupancy 0..DEPTH
//   empty_o, full_o       occupancy extremes
//   almost_full_o         count_o >= AF_THRESH
//   almost_empty_o        count_o <= AE_THRESH
//   overflow_o            sticky: push attempted while full
//   underflow_o           sticky: pop attempted while empty
//   wm_clear_i            (FIFO_WATERMARK_EN) clears only the high-water mark
//   high_water_o          (FIFO_WATERMARK_EN) peak count_o since reset/clear

module param_fifo_buffer #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 5,
   parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_i,
`ifdef FIFO_WATERMARK_EN
   input  logic                  wm_clear_i,
   output logic [ADDR_WIDTH:0]   high_water_o,
`endif
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

   // Thresholds outside 0..DEPTH make the flags meaningless; stop elaboration.
   if ((AF_THRESH < 0) || (AF_THRESH > DEPTH)) begin : g_af_thresh_illegal
      $error("param_fifo_buffer: AF_THRESH outside 0..DEPTH");
   end
   if ((AE_THRESH < 0) || (AE_THRESH > DEPTH)) begin : g_ae_thresh_illegal
      $error("param_fifo_buffer: AE_THRESH outside 0..DEPTH");
   end

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_flush;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH:0]   w_count_next;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_flush = reset | clear_i;

   // A flush in the same cycle discards the transfer, so it must not touch memory either.
   assign w_push = wr_valid_i & ~w_full  & ~w_flush;
   assign w_pop  = rd_ready_i & ~w_empty & ~w_flush;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Storage has no reset; contents survive reset/clear and are masked by the count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
         if (wr_valid_i && w_full) begin
            r_overflow <= 1'b1;
         end
         if (rd_ready_i && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

`ifdef FIFO_WATERMARK_EN
   logic [ADDR_WIDTH:0] r_high_water;

   // Tracks the next count so the mark moves on the same edge as count_o.
   always_ff @(posedge clk) begin
      if (w_flush || wm_clear_i) begin
         r_high_water <= '0;
      end else if (w_count_next > r_high_water) begin
         r_high_water <= w_count_next;
      end
   end

   assign high_water_o = r_high_water;
`endif

   assign count_o        = r_count;
   assign empty_o        = w_empty;
   assign full_o         = w_full;
   assign wr_ready_o     = ~w_full;
   assign rd_valid_o     = ~w_empty;
   assign rd_data_o      = r_mem[r_rd_ptr];
   assign almost_full_o  = (r_count >= C_AF);
   assign almost_empty_o = (r_count <= C_AE);
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

endmodule
